// File: rtl/toy_bpu_btb_upd_buffer.sv
// BTB training-update buffer: a circular queue of resolved-branch updates that
// coalesces repeats, exposes every slot for lookup bypass and drains into idle BTB port cycles.

package btb_entry_buffer_pkg;

   typedef struct packed {
      logic [7:0]  index;
      logic [11:0] tag;
      logic [31:0] entry;
      logic [3:0]  way_hit;
      logic        real_taken;
   } btb_entry_buffer_t;

endpackage

// Invariant checker: unique match, occupancy agrees with the valid mask, no push into a full buffer.
module toy_bpu_btb_upd_buffer_chk #(
   parameter int ENTRY_BUFFER_NUM       = 8,
   parameter int ENTRY_BUFFER_PTR_WIDTH = 3
) (
   input logic                              clk_i,
   input logic                              rst_ni,
   input logic                              upd_vld_i,
   input logic                              upd_rdy_i,
   input logic                              full_i,
   input logic [ENTRY_BUFFER_NUM-1:0]       hit_vec_i,
   input logic [ENTRY_BUFFER_NUM-1:0]       ena_i,
   input logic [ENTRY_BUFFER_PTR_WIDTH:0]   wr_ptr_i,
   input logic [ENTRY_BUFFER_PTR_WIDTH:0]   rd_ptr_i
);

   logic [ENTRY_BUFFER_PTR_WIDTH:0] occ_s;

   // Occupancy implied by the pointer pair.
   always_comb begin
      occ_s = wr_ptr_i - rd_ptr_i;
   end

   a_single_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
      upd_vld_i |-> $onehot0(hit_vec_i));

   a_ena_matches_occ: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $countones(ena_i) == int'(occ_s));

   a_no_rdy_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      full_i |-> !upd_rdy_i);

endmodule

module toy_bpu_btb_upd_buffer
   import btb_entry_buffer_pkg::*;
#(
   parameter int ENTRY_BUFFER_NUM       = 8,
   parameter int ENTRY_BUFFER_PTR_WIDTH = 3
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic                                     upd_vld_i,
   output logic                                     upd_rdy_o,
   input  btb_entry_buffer_t                        upd_pld_i,
   output btb_entry_buffer_t [ENTRY_BUFFER_NUM-1:0] entry_buffer_pld_o,
   output logic [ENTRY_BUFFER_PTR_WIDTH:0]          entry_buffer_ptr_o,
   output logic [ENTRY_BUFFER_NUM-1:0]              entry_buffer_ena_o,
   input  logic                                     btb_update_vld_i,
   output logic                                     btb_update_rdy_o,
   output btb_entry_buffer_t                        btb_update_pld_o
);

   localparam int N  = ENTRY_BUFFER_NUM;
   localparam int PW = ENTRY_BUFFER_PTR_WIDTH;
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   btb_entry_buffer_t [N-1:0] slot_q, slot_d;
   logic [N-1:0]              ena_q, ena_d;
   logic [PW:0]               wr_ptr_q, wr_ptr_d;
   logic [PW:0]               rd_ptr_q, rd_ptr_d;

   logic [PW-1:0] wr_idx_s;
   logic [PW-1:0] rd_idx_s;
   logic          empty_s;
   logic          full_s;
   logic          push_s;
   logic          pop_s;
   logic [N-1:0]  hit_vec_s;
   logic [N-1:0]  pop_mask_s;
   logic [N-1:0]  eff_hit_s;
   logic          coalesce_s;
   logic          alloc_s;

   // Queue status and handshakes, derived from registered pointers only.
   always_comb begin
      wr_idx_s  = wr_ptr_q[PW-1:0];
      rd_idx_s  = rd_ptr_q[PW-1:0];
      empty_s   = (wr_ptr_q == rd_ptr_q);
      full_s    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx_s == rd_idx_s);
      upd_rdy_o        = !full_s;
      btb_update_rdy_o = !empty_s;
      push_s    = upd_vld_i && !full_s;
      pop_s     = btb_update_vld_i && !empty_s;
   end

   // Match the incoming update against live slots; a slot leaving this cycle cannot absorb it.
   always_comb begin
      hit_vec_s  = '0;
      pop_mask_s = '0;
      for (int k = 0; k < N; k++) begin
         hit_vec_s[k]  = ena_q[k] &&
                         (slot_q[k].index == upd_pld_i.index) &&
                         (slot_q[k].tag   == upd_pld_i.tag);
         pop_mask_s[k] = pop_s && (rd_idx_s == PW'(k));
      end
      eff_hit_s  = hit_vec_s & ~pop_mask_s;
      coalesce_s = push_s && (|eff_hit_s);
      alloc_s    = push_s && !(|eff_hit_s);
   end

   // Next-state: coalesce overwrite, pop retire, allocate at the write pointer.
   always_comb begin
      slot_d   = slot_q;
      ena_d    = ena_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      for (int k = 0; k < N; k++) begin
         slot_d[k] = (coalesce_s && eff_hit_s[k]) ? upd_pld_i : slot_q[k];
      end
      if (pop_s) begin
         ena_d[rd_idx_s] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d        = rd_ptr_q;
      end
      // Allocation never lands on the popped slot: pop needs non-empty, push needs non-full.
      if (alloc_s) begin
         slot_d[wr_idx_s] = upd_pld_i;
         ena_d[wr_idx_s]  = 1'b1;
         wr_ptr_d         = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d         = wr_ptr_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q   <= '0;
         ena_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         slot_q   <= slot_d;
         ena_q    <= ena_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Bypass view and drain head, straight from the registers.
   always_comb begin
      entry_buffer_pld_o = slot_q;
      entry_buffer_ena_o = ena_q;
      entry_buffer_ptr_o = wr_ptr_q;
      btb_update_pld_o   = slot_q[rd_idx_s];
   end

   toy_bpu_btb_upd_buffer_chk #(
      .ENTRY_BUFFER_NUM       (N),
      .ENTRY_BUFFER_PTR_WIDTH (PW)
   ) u_chk (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .upd_vld_i (upd_vld_i),
      .upd_rdy_i (upd_rdy_o),
      .full_i    (full_s),
      .hit_vec_i (hit_vec_s),
      .ena_i     (ena_q),
      .wr_ptr_i  (wr_ptr_q),
      .rd_ptr_i  (rd_ptr_q)
   );

endmodule

// File: tb/tb_toy_bpu_btb_upd_buffer.sv
// Scoreboard bench for toy_bpu_btb_upd_buffer: a queue model of pending updates
// (oldest first, coalescing) predicts handshakes, pointer, valid mask and drain order.

module tb_toy_bpu_btb_upd_buffer;
   import btb_entry_buffer_pkg::*;

   localparam int N = 8;

   logic                      clk;
   logic                      rst_n;
   logic                      upd_vld;
   logic                      upd_rdy;
   btb_entry_buffer_t         upd_pld;
   btb_entry_buffer_t [N-1:0] eb_pld;
   logic [3:0]                eb_ptr;
   logic [N-1:0]              eb_ena;
   logic                      btb_vld;
   logic                      btb_rdy;
   btb_entry_buffer_t         btb_pld;

   btb_entry_buffer_t model_q[$];
   int exp_wr;
   int exp_rd;
   int err_cnt;
   int chk_cnt;

   toy_bpu_btb_upd_buffer dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .upd_vld_i          (upd_vld),
      .upd_rdy_o          (upd_rdy),
      .upd_pld_i          (upd_pld),
      .entry_buffer_pld_o (eb_pld),
      .entry_buffer_ptr_o (eb_ptr),
      .entry_buffer_ena_o (eb_ena),
      .btb_update_vld_i   (btb_vld),
      .btb_update_rdy_o   (btb_rdy),
      .btb_update_pld_o   (btb_pld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic btb_entry_buffer_t mk(input logic [7:0] idx, input logic [11:0] tg,
                                            input logic [3:0] wh, input logic [31:0] tgt);
      btb_entry_buffer_t e;
      e.index      = idx;
      e.tag        = tg;
      e.entry      = tgt;
      e.way_hit    = wh;
      e.real_taken = tgt[0];
      return e;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      upd_vld = 1'b0;
      btb_vld = 1'b0;
      upd_pld = '0;
      model_q.delete();
      exp_wr  = 0;
      exp_rd  = 0;
      #3;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock: drive, check pre-edge outputs against the model, advance the model, take the edge.
   task automatic step(input bit pv, input btb_entry_buffer_t p, input bit bv);
      logic [N-1:0] m;
      int           sz;
      int           hit;
      @(negedge clk);
      upd_vld = pv;
      upd_pld = p;
      btb_vld = bv;
      #1;
      sz = model_q.size();
      check_eq("upd_rdy", 64'(upd_rdy), 64'(sz < N));
      check_eq("btb_rdy", 64'(btb_rdy), 64'(sz != 0));
      check_eq("ptr", 64'(eb_ptr), 64'(exp_wr));
      m = '0;
      for (int i = 0; i < sz; i++) m[(exp_rd + i) % N] = 1'b1;
      check_eq("ena", 64'(eb_ena), 64'(m));
      if (sz != 0) check_eq("btb_pld", 64'(btb_pld), 64'(model_q[0]));
      if (bv && sz != 0) begin
         void'(model_q.pop_front());
         exp_rd = (exp_rd + 1) % 16;
      end
      if (pv && sz < N) begin
         hit = -1;
         foreach (model_q[i]) begin
            if (model_q[i].index == p.index && model_q[i].tag == p.tag) hit = i;
         end
         if (hit >= 0) begin
            model_q[hit] = p;
         end else begin
            model_q.push_back(p);
            exp_wr = (exp_wr + 1) % 16;
         end
      end
      @(posedge clk);
      #1;
      upd_vld = 1'b0;
      btb_vld = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
   endtask

   initial begin
      btb_entry_buffer_t a;
      btb_entry_buffer_t e;
      err_cnt = 0;
      chk_cnt = 0;
      rst_n   = 1'b0;
      upd_vld = 1'b0;
      btb_vld = 1'b0;
      upd_pld = '0;

      // T1 reset state
      do_reset();
      #1;
      check_eq("rst_ena", 64'(eb_ena), 64'h0);
      check_eq("rst_ptr", 64'(eb_ptr), 64'h0);
      check_eq("rst_upd_rdy", 64'(upd_rdy), 64'h1);
      check_eq("rst_btb_rdy", 64'(btb_rdy), 64'h0);
      check_eq("rst_btb_pld", 64'(btb_pld), 64'h0);

      // T2 single push, no drain
      step(1'b1, mk(8'h12, 12'h3, 4'h1, 32'h0000_1000), 1'b0);
      check_eq("t2_ena", 64'(eb_ena), 64'h01);
      check_eq("t2_ptr", 64'(eb_ptr), 64'h1);
      check_eq("t2_btb_rdy", 64'(btb_rdy), 64'h1);
      check_eq("t2_index", 64'(btb_pld.index), 64'h12);
      step(1'b0, '0, 1'b0);
      drain(1);

      // T3 fill, hold the 9th, drain one
      do_reset();
      for (int i = 0; i < N; i++) step(1'b1, mk(8'h20 + 8'(i), 12'h7, 4'h2, 32'(i * 4)), 1'b0);
      check_eq("t3_ptr_full", 64'(eb_ptr), 64'h8);
      check_eq("t3_upd_rdy_full", 64'(upd_rdy), 64'h0);
      step(1'b1, mk(8'h7f, 12'h7, 4'h2, 32'h0000_0555), 1'b0);
      check_eq("t3_ptr_held", 64'(eb_ptr), 64'h8);
      step(1'b0, '0, 1'b1);
      check_eq("t3_upd_rdy_after", 64'(upd_rdy), 64'h1);
      drain(N - 1);

      // T4 coalesce
      do_reset();
      a = mk(8'h12, 12'h3, 4'b0001, 32'h0000_2000);
      step(1'b1, a, 1'b0);
      step(1'b1, mk(8'h40, 12'h1, 4'b0100, 32'h0000_3000), 1'b0);
      a = mk(8'h12, 12'h3, 4'b0010, 32'h0000_2004);
      step(1'b1, a, 1'b0);
      check_eq("t4_ptr", 64'(eb_ptr), 64'h2);
      check_eq("t4_slot0_wh", 64'(eb_pld[0].way_hit), 64'h2);
      check_eq("t4_slot1_idx", 64'(eb_pld[1].index), 64'h40);
      check_eq("t4_head_is_a2", 64'(btb_pld), 64'(a));
      drain(2);

      // T5 steady push+pop with 3 resident, through a pointer wrap
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, mk(8'h80 + 8'(i), 12'h9, 4'h8, 32'(i)), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, mk(8'h90 + 8'(i), 12'h9, 4'h8, 32'(100 + i)), 1'b1);
      check_eq("t5_ena_cnt", 64'($countones(eb_ena)), 64'h3);
      check_eq("t5_ptr", 64'(eb_ptr), 64'(23 % 16));
      drain(3);

      // T6 push hitting the slot being popped
      do_reset();
      step(1'b1, mk(8'h33, 12'h5, 4'h1, 32'h0000_0011), 1'b0);
      step(1'b1, mk(8'h44, 12'h6, 4'h2, 32'h0000_0022), 1'b0);
      e = mk(8'h33, 12'h5, 4'h4, 32'h0000_0033);
      step(1'b1, e, 1'b1);
      check_eq("t6_ptr", 64'(eb_ptr), 64'h3);
      check_eq("t6_ena_cnt", 64'($countones(eb_ena)), 64'h2);
      check_eq("t6_new_slot", 64'(eb_pld[2]), 64'(e));
      drain(2);

      // Reset mid-operation clears everything
      step(1'b1, mk(8'h01, 12'h1, 4'h1, 32'h1), 1'b0);
      step(1'b1, mk(8'h02, 12'h1, 4'h1, 32'h2), 1'b0);
      do_reset();
      #1;
      check_eq("mid_rst_ena", 64'(eb_ena), 64'h0);
      check_eq("mid_rst_ptr", 64'(eb_ptr), 64'h0);

      // Mixed traffic over a small key space to exercise coalescing and backpressure
      for (int i = 0; i < 120; i++) begin
         step(1'($urandom_range(0, 3) != 0),
              mk(8'($urandom_range(0, 5)), 12'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'($urandom)),
              1'($urandom_range(0, 2) == 0));
      end
      drain(N);
      check_eq("end_empty_rdy", 64'(btb_rdy), 64'h0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
